// File: rtl/riscv_ctrl_pkg.sv
// Shared decode constants, ImmSel/state encodings and the ID/EX control bundle
// for the id_ctrl_stage decode controller.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'b000,
        IMM_I    = 3'b001,
        IMM_S    = 3'b010,
        IMM_B    = 3'b011,
        IMM_J    = 3'b100,
        IMM_U    = 3'b101
    } imm_sel_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    typedef struct packed {
        imm_sel_e imm_sel;
        logic     reg_write;
        logic     mem_read;
        logic     mem_write;
        logic     alu_src;
        logic     branch;
        logic     jump;
    } ctrl_t;

endpackage

// File: rtl/id_ctrl_stage_if.sv
// Front-end / ID-EX signal bundle for id_ctrl_stage.
// IllegalInstr exists only when ID_ILLEGAL_TRAP_EN is defined.
interface id_ctrl_stage_if #(
    parameter int unsigned CNT_W = 16
);
    logic             IfIdValid;
    logic [31:0]      IfIdInstr;
    logic             ExValid;
    logic             ExMemRead;
    logic [4:0]       ExRd;
    logic             BranchTaken;
    logic             Resume;
    logic             PCWrite;
    logic             IfIdWrite;
    logic             IfIdFlush;
    logic             IdExValid;
    logic [2:0]       IdExImmSel;
    logic             IdExRegWrite;
    logic             IdExMemRead;
    logic             IdExMemWrite;
    logic             IdExALUSrc;
    logic             IdExBranch;
    logic             IdExJump;
    logic [4:0]       IdExRd;
    logic             Halted;
    logic [CNT_W-1:0] StallCount;
`ifdef ID_ILLEGAL_TRAP_EN
    logic             IllegalInstr;
`endif

    modport slave (
`ifdef ID_ILLEGAL_TRAP_EN
        output IllegalInstr,
`endif
        input  IfIdValid, IfIdInstr, ExValid, ExMemRead, ExRd, BranchTaken, Resume,
        output PCWrite, IfIdWrite, IfIdFlush, IdExValid, IdExImmSel,
        output IdExRegWrite, IdExMemRead, IdExMemWrite, IdExALUSrc, IdExBranch, IdExJump,
        output IdExRd, Halted, StallCount
    );

    modport master (
`ifdef ID_ILLEGAL_TRAP_EN
        input  IllegalInstr,
`endif
        output IfIdValid, IfIdInstr, ExValid, ExMemRead, ExRd, BranchTaken, Resume,
        input  PCWrite, IfIdWrite, IfIdFlush, IdExValid, IdExImmSel,
        input  IdExRegWrite, IdExMemRead, IdExMemWrite, IdExALUSrc, IdExBranch, IdExJump,
        input  IdExRd, Halted, StallCount
    );

endinterface

// File: rtl/ctrl_decode.sv
// Purely combinational opcode decoder: control bundle, rs1/rs2 use flags,
// SYSTEM and illegal-opcode flags.
module ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output ctrl_t      o_ctrl,
    output logic       o_rs1_used,
    output logic       o_rs2_used,
    output logic       o_system,
    output logic       o_illegal
);

    always_comb begin
        o_ctrl     = '0;
        o_rs1_used = 1'b0;
        o_rs2_used = 1'b0;
        o_system   = 1'b0;
        o_illegal  = 1'b0;
        case (i_opcode)
            OPC_LUI, OPC_AUIPC: begin
                o_ctrl.imm_sel   = IMM_U;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
            end
            OPC_JAL: begin
                o_ctrl.imm_sel   = IMM_J;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.jump      = 1'b1;
            end
            OPC_JALR: begin
                o_ctrl.imm_sel   = IMM_I;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.jump      = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_rs1_used       = 1'b1;
            end
            OPC_BRANCH: begin
                o_ctrl.imm_sel   = IMM_B;
                o_ctrl.branch    = 1'b1;
                o_rs1_used       = 1'b1;
                o_rs2_used       = 1'b1;
            end
            OPC_LOAD: begin
                o_ctrl.imm_sel   = IMM_I;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_rs1_used       = 1'b1;
            end
            OPC_STORE: begin
                o_ctrl.imm_sel   = IMM_S;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_rs1_used       = 1'b1;
                o_rs2_used       = 1'b1;
            end
            OPC_OP_IMM: begin
                o_ctrl.imm_sel   = IMM_I;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_rs1_used       = 1'b1;
            end
            OPC_OP: begin
                o_ctrl.reg_write = 1'b1;
                o_rs1_used       = 1'b1;
                o_rs2_used       = 1'b1;
            end
            OPC_SYSTEM: o_system = 1'b1;
            default:    o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ctrl_stage.sv
// Decode-stage controller: load-use hazard stall, branch flush, SYSTEM halt FSM
// and ID/EX control register. Optional feature macro: ID_ILLEGAL_TRAP_EN.
module id_ctrl_stage
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    id_ctrl_stage_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic [4:0]       w_rd;
    ctrl_t            w_dec_ctrl;
    logic             w_rs1_used;
    logic             w_rs2_used;
    logic             w_system;
    logic             w_illegal;
    logic             w_hazard;
    logic             w_unused_bits;

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_valid;
    ctrl_t            r_ctrl;
    logic [4:0]       r_rd;
    logic [CNT_W-1:0] r_stall_count;

    logic             w_pc_write;
    logic             w_valid_d;
    ctrl_t            w_ctrl_d;
    logic [4:0]       w_rd_d;
    logic             w_stall_inc;
`ifdef ID_ILLEGAL_TRAP_EN
    logic             r_illegal;
    logic             w_illegal_set;
`endif

    assign w_rd          = bus.IfIdInstr[11:7];
    assign w_rs1         = bus.IfIdInstr[19:15];
    assign w_rs2         = bus.IfIdInstr[24:20];
    assign w_unused_bits = ^{bus.IfIdInstr[31:25], bus.IfIdInstr[14:12]};

    ctrl_decode u_decode (
        .i_opcode   (bus.IfIdInstr[6:0]),
        .o_ctrl     (w_dec_ctrl),
        .o_rs1_used (w_rs1_used),
        .o_rs2_used (w_rs2_used),
        .o_system   (w_system),
        .o_illegal  (w_illegal)
    );

    assign w_hazard = bus.IfIdValid && bus.ExValid && bus.ExMemRead && (bus.ExRd != 5'd0)
                   && ((w_rs1_used && (w_rs1 == bus.ExRd)) || (w_rs2_used && (w_rs2 == bus.ExRd)));

    always_comb begin
        w_state_nxt = r_state;
        w_pc_write  = 1'b1;
        w_valid_d   = 1'b0;
        w_ctrl_d    = '0;
        w_rd_d      = '0;
        w_stall_inc = 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
        w_illegal_set = 1'b0;
`endif
        case (r_state)
            ST_HALT: begin
                w_pc_write = 1'b0;
                if (bus.Resume) w_state_nxt = ST_RUN;
            end
            default: begin
                if (bus.BranchTaken) begin
                    w_valid_d = 1'b0;
                end else if (w_hazard) begin
                    w_pc_write  = 1'b0;
                    w_stall_inc = 1'b1;
                end else if (bus.IfIdValid && w_system) begin
                    w_state_nxt = ST_HALT;
                end else if (bus.IfIdValid && w_illegal) begin
`ifdef ID_ILLEGAL_TRAP_EN
                    w_illegal_set = 1'b1;
                    w_state_nxt   = ST_HALT;
`endif
                end else begin
                    w_valid_d = bus.IfIdValid;
                    w_ctrl_d  = w_dec_ctrl;
                    w_rd_d    = w_rd;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_valid       <= 1'b0;
            r_ctrl        <= '0;
            r_rd          <= '0;
            r_stall_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_d;
            r_ctrl  <= w_ctrl_d;
            r_rd    <= w_rd_d;
            if (w_stall_inc && (r_stall_count != CNT_MAX)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

`ifdef ID_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (w_illegal_set) begin
            r_illegal <= 1'b1;
        end
    end

    assign bus.IllegalInstr = r_illegal;
`endif

    assign bus.PCWrite      = w_pc_write;
    assign bus.IfIdWrite    = w_pc_write;
    assign bus.IfIdFlush    = bus.BranchTaken;
    assign bus.IdExValid    = r_valid;
    assign bus.IdExImmSel   = r_ctrl.imm_sel;
    assign bus.IdExRegWrite = r_ctrl.reg_write;
    assign bus.IdExMemRead  = r_ctrl.mem_read;
    assign bus.IdExMemWrite = r_ctrl.mem_write;
    assign bus.IdExALUSrc   = r_ctrl.alu_src;
    assign bus.IdExBranch   = r_ctrl.branch;
    assign bus.IdExJump     = r_ctrl.jump;
    assign bus.IdExRd       = r_rd;
    assign bus.Halted       = (r_state == ST_HALT);
    assign bus.StallCount   = r_stall_count;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Self-checking bench for id_ctrl_stage: directed scenarios then random cycles,
// all checked against a table-driven behavioural model.
module tb_id_ctrl_stage;

    localparam int unsigned TB_CNT_W = 4;
    localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ctrl_stage_if #(.CNT_W(TB_CNT_W)) bus ();

    id_ctrl_stage #(.CNT_W(TB_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Per-opcode expectations: ImmSel code, controls, register use, class.
    typedef struct {
        int imm;
        bit rw, mr, mw, as, br, jp, u1, u2, sys, legal;
    } row_t;

    row_t tab [128];

    int n_checks = 0;
    int n_fail   = 0;

    bit   m_halt, m_valid, m_ill;
    int   m_cnt;
    row_t m_row;
    int   m_rd;

    logic [6:0] ops [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                             7'h23, 7'h13, 7'h33, 7'h73, 7'h00, 7'h7F};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic add_row(input logic [6:0] op, input int imm,
                           input bit rw, input bit mr, input bit mw, input bit as,
                           input bit br, input bit jp, input bit u1, input bit u2,
                           input bit sys);
        tab[op] = '{imm, rw, mr, mw, as, br, jp, u1, u2, sys, 1'b1};
    endtask

    task automatic step(input bit r, input bit v, input logic [31:0] ins,
                        input bit exv, input bit exmr, input logic [4:0] exrd,
                        input bit bt, input bit res);
        row_t row;
        bit   hz;
        bit   exp_pcw;
        @(negedge clk);
        rst             = r;
        bus.IfIdValid   = v;
        bus.IfIdInstr   = ins;
        bus.ExValid     = exv;
        bus.ExMemRead   = exmr;
        bus.ExRd        = exrd;
        bus.BranchTaken = bt;
        bus.Resume      = res;
        #1;
        row = tab[ins[6:0]];
        hz  = v && exv && exmr && (exrd != 0)
           && ((row.u1 && ins[19:15] == exrd) || (row.u2 && ins[24:20] == exrd));
        if (!r) begin
            exp_pcw = !m_halt && (bt || !hz);
            chk("PCWrite", 32'(bus.PCWrite), 32'(exp_pcw));
            chk("IfIdWrite", 32'(bus.IfIdWrite), 32'(exp_pcw));
            chk("IfIdFlush", 32'(bus.IfIdFlush), 32'(bt));
        end
        @(posedge clk);
        if (r) begin
            m_halt = 0; m_valid = 0; m_ill = 0; m_cnt = 0;
        end else if (m_halt) begin
            m_valid = 0;
            if (res) m_halt = 0;
        end else if (bt) begin
            m_valid = 0;
        end else if (hz) begin
            m_valid = 0;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else if (v && row.sys) begin
            m_valid = 0;
            m_halt  = 1;
        end else if (v && !row.legal) begin
            m_valid = 0;
`ifdef ID_ILLEGAL_TRAP_EN
            m_ill  = 1;
            m_halt = 1;
`endif
        end else begin
            m_valid = v;
            m_row   = row;
            m_rd    = int'(ins[11:7]);
        end
        #1;
        chk("Halted", 32'(bus.Halted), 32'(m_halt));
        chk("IdExValid", 32'(bus.IdExValid), 32'(m_valid));
        chk("StallCount", 32'(bus.StallCount), 32'(m_cnt));
`ifdef ID_ILLEGAL_TRAP_EN
        chk("IllegalInstr", 32'(bus.IllegalInstr), 32'(m_ill));
`endif
        if (m_valid) begin
            chk("ImmSel", 32'(bus.IdExImmSel), 32'(m_row.imm));
            chk("RegWrite", 32'(bus.IdExRegWrite), 32'(m_row.rw));
            chk("MemRead", 32'(bus.IdExMemRead), 32'(m_row.mr));
            chk("MemWrite", 32'(bus.IdExMemWrite), 32'(m_row.mw));
            chk("ALUSrc", 32'(bus.IdExALUSrc), 32'(m_row.as));
            chk("Branch", 32'(bus.IdExBranch), 32'(m_row.br));
            chk("Jump", 32'(bus.IdExJump), 32'(m_row.jp));
            chk("IdExRd", 32'(bus.IdExRd), 32'(m_rd));
        end
    endtask

    task automatic idle(input logic [31:0] ins, input bit res);
        step(1'b0, 1'b1, ins, 1'b0, 1'b0, 5'd0, 1'b0, res);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] x;
        x        = $urandom;
        x[24:20] = 5'($urandom_range(0, 3));
        x[19:15] = 5'($urandom_range(0, 3));
        x[6:0]   = ops[$urandom_range(0, 11)];
        return x;
    endfunction

    localparam logic [31:0] ADDI  = 32'h00500093;
    localparam logic [31:0] ADD   = 32'h001101B3;
    localparam logic [31:0] LUI   = 32'h000102B7;
    localparam logic [31:0] ECALL = 32'h00000073;
    localparam logic [31:0] BAD   = 32'hFFFFFFFF;

    initial begin
        for (int i = 0; i < 128; i++) tab[i] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        //        op      imm rw mr mw as br jp u1 u2 sys
        add_row(7'h37, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        add_row(7'h17, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        add_row(7'h6F, 4, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        add_row(7'h67, 1, 1, 0, 0, 1, 0, 1, 1, 0, 0);
        add_row(7'h63, 3, 0, 0, 0, 0, 1, 0, 1, 1, 0);
        add_row(7'h03, 1, 1, 1, 0, 1, 0, 0, 1, 0, 0);
        add_row(7'h23, 2, 0, 0, 1, 1, 0, 0, 1, 1, 0);
        add_row(7'h13, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0);
        add_row(7'h33, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        add_row(7'h73, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        m_halt = 0; m_valid = 0; m_ill = 0; m_cnt = 0; m_rd = 0; m_row = tab[0];
        rst = 1'b1;
        bus.IfIdValid = 0; bus.IfIdInstr = '0; bus.ExValid = 0; bus.ExMemRead = 0;
        bus.ExRd = '0; bus.BranchTaken = 0; bus.Resume = 0;

        step(1, 0, '0, 0, 0, 5'd0, 0, 0);
        step(1, 1, ADDI, 1, 1, 5'd1, 1, 1);
        chk("reset_valid", 32'(bus.IdExValid), 32'd0);

        idle(ADDI, 0);
        chk("addi_immsel", 32'(bus.IdExImmSel), 32'd1);
        chk("addi_rd", 32'(bus.IdExRd), 32'd1);

        step(0, 1, ADD, 1, 1, 5'd2, 0, 0);
        chk("loaduse_cnt", 32'(bus.StallCount), 32'd1);
        step(0, 1, ADD, 0, 0, 5'd0, 0, 0);
        chk("add_issue", 32'(bus.IdExValid), 32'd1);

        step(0, 1, LUI, 1, 1, 5'd2, 0, 0);
        chk("lui_immsel", 32'(bus.IdExImmSel), 32'd5);

        step(0, 1, ADD, 1, 1, 5'd2, 1, 0);
        chk("flush_cnt", 32'(bus.StallCount), 32'd1);

        // x0 as load destination never stalls
        step(0, 1, ADD, 1, 1, 5'd0, 0, 0);

        for (int i = 0; i < 20; i++) step(0, 1, ADD, 1, 1, 5'd1, 0, 0);
        chk("stall_saturate", 32'(bus.StallCount), 32'(CNT_MAX));

        idle(ECALL, 0);
        chk("ecall_halt", 32'(bus.Halted), 32'd1);
        for (int i = 0; i < 5; i++) step(0, 1, ADDI, 0, 0, 5'd0, i == 2, 0);
        idle(ADDI, 1);
        chk("resume_run", 32'(bus.Halted), 32'd0);
        idle(ADDI, 1);
        chk("resume_decode", 32'(bus.IdExValid), 32'd1);

        idle(ECALL, 0);
        idle(ADDI, 0);
        step(1, 1, ADDI, 0, 0, 5'd0, 0, 0);
        chk("rst_halt", 32'(bus.Halted), 32'd0);
        chk("rst_cnt", 32'(bus.StallCount), 32'd0);

        idle(BAD, 0);
        idle(ADDI, 0);
        idle(ADDI, 1);
        idle(ADDI, 0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0, rand_instr(),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
